// File: rtl/dfr_pkg.sv
// Shared types for the DFR phase sequencer: externally visible phase codes and internal FSM states.
package dfr_pkg;

    localparam int PHASE_W = 3;

    typedef enum logic [PHASE_W-1:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        CLEAR = 3'd2,
        INIT  = 3'd3,
        RUN   = 3'd4,
        DRAIN = 3'd5,
        MM    = 3'd6,
        DONE  = 3'd7
    } phase_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_CLEAR,
        S_INIT,
        S_RUN,
        S_DRAIN,
        S_MM_START,
        S_MM_WAIT,
        S_DONE,
        S_ABORT
    } state_t;

    // ABORT is transient and reports IDLE so software never sees a half-cancelled run.
    function automatic phase_t state_to_phase(input state_t s);
        case (s)
            S_CHECK:    return CHECK;
            S_CLEAR:    return CLEAR;
            S_INIT:     return INIT;
            S_RUN:      return RUN;
            S_DRAIN:    return DRAIN;
            S_MM_START,
            S_MM_WAIT:  return MM;
            S_DONE:     return DONE;
            default:    return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/dfr_delay_line.sv
// Single-bit shift pipe used to align issue strobes with RAM and reservoir latency.
module dfr_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] pipe_q;

    // NOTE: non-blocking assignments make every stage sample the previous stage's old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
        end else if (flush) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/dfr_phase_sequencer.sv
// Sequences one DFR run: config check, reservoir clear, warm-up, sampled run with history capture, matrix multiply.
module dfr_phase_sequencer
    import dfr_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int CNT_WIDTH   = 32,
    parameter int RD_LATENCY  = 1,
    parameter int RES_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CNT_WIDTH-1:0]  cfg_init_steps,
    input  logic [ADDR_WIDTH-1:0] cfg_steps_per_sample,
    input  logic [ADDR_WIDTH-1:0] cfg_num_samples,
    input  logic [ADDR_WIDTH-1:0] cfg_num_outputs,
    input  logic                  cfg_skip_mm,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [PHASE_W-1:0]    phase,
    output logic [ADDR_WIDTH-1:0] input_addr,
    output logic                  reservoir_en,
    output logic                  reservoir_rst,
    output logic                  history_wen,
    output logic [ADDR_WIDTH-1:0] history_addr,
    output logic                  mm_start,
    output logic                  mm_rst,
    input  logic                  mm_busy,
    output logic [ADDR_WIDTH-1:0] mm_x_rows,
    output logic [ADDR_WIDTH-1:0] mm_x_cols,
    output logic [ADDR_WIDTH-1:0] mm_y_cols
);

    localparam int WEN_DEPTH = RD_LATENCY + RES_LATENCY;
    localparam int DRAIN_W   = $clog2(WEN_DEPTH) + 1;
    localparam logic [2*ADDR_WIDTH-1:0] MAX_TOTAL =
        {{(ADDR_WIDTH-1){1'b0}}, 1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                  state_q;
    logic                    start_q;
    logic                    busy_q, done_q, err_q;
    logic                    res_rst_q, mm_rst_q, mm_start_q, mm_first_q;
    logic                    issue_q, run_issue_q;
    logic [ADDR_WIDTH-1:0]   addr_q, hist_addr_q;
    logic [CNT_WIDTH-1:0]    init_cfg_q, init_cnt_q;
    logic [ADDR_WIDTH-1:0]   steps_q, samples_q, outputs_q;
    logic                    skip_mm_q;
    logic [ADDR_WIDTH:0]     total_q, run_cnt_q;
    logic [DRAIN_W-1:0]      drain_cnt_q;

    logic [2*ADDR_WIDTH-1:0] total_d;
    logic                    cfg_ok;
    logic                    start_edge;
    logic                    abort_hit;
    logic                    res_en_w, hist_wen_w;

    // Full-width product so that oversized runs are caught rather than silently wrapped.
    assign total_d    = {{ADDR_WIDTH{1'b0}}, steps_q} * {{ADDR_WIDTH{1'b0}}, samples_q};
    assign cfg_ok     = (steps_q != '0) && (samples_q != '0) && (total_d <= MAX_TOTAL);
    assign start_edge = start && !start_q;
    assign abort_hit  = abort && (state_q != S_IDLE) && (state_q != S_ABORT);

    dfr_delay_line #(.DEPTH(RD_LATENCY)) u_en_delay (
        .clk   (clk),
        .rst   (rst),
        .flush (abort_hit),
        .din   (issue_q),
        .dout  (res_en_w)
    );

    dfr_delay_line #(.DEPTH(WEN_DEPTH)) u_wen_delay (
        .clk   (clk),
        .rst   (rst),
        .flush (abort_hit),
        .din   (run_issue_q),
        .dout  (hist_wen_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            res_rst_q   <= 1'b0;
            mm_rst_q    <= 1'b0;
            mm_start_q  <= 1'b0;
            mm_first_q  <= 1'b0;
            issue_q     <= 1'b0;
            run_issue_q <= 1'b0;
            addr_q      <= '0;
            hist_addr_q <= '0;
            init_cfg_q  <= '0;
            init_cnt_q  <= '0;
            steps_q     <= '0;
            samples_q   <= '0;
            outputs_q   <= '0;
            skip_mm_q   <= 1'b0;
            total_q     <= '0;
            run_cnt_q   <= '0;
            drain_cnt_q <= '0;
        end else begin
            start_q <= start;
            if (hist_wen_w) begin
                hist_addr_q <= hist_addr_q + 1'b1;
            end

            if (abort_hit) begin
                state_q     <= S_ABORT;
                busy_q      <= 1'b0;
                done_q      <= 1'b0;
                mm_start_q  <= 1'b0;
                issue_q     <= 1'b0;
                run_issue_q <= 1'b0;
                res_rst_q   <= 1'b1;
                mm_rst_q    <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_edge) begin
                            init_cfg_q <= cfg_init_steps;
                            steps_q    <= cfg_steps_per_sample;
                            samples_q  <= cfg_num_samples;
                            outputs_q  <= cfg_num_outputs;
                            skip_mm_q  <= cfg_skip_mm;
                            err_q      <= 1'b0;
                            busy_q     <= 1'b1;
                            state_q    <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (cfg_ok) begin
                            total_q   <= total_d[ADDR_WIDTH:0];
                            res_rst_q <= 1'b1;
                            mm_rst_q  <= 1'b1;
                            state_q   <= S_CLEAR;
                        end else begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                    S_CLEAR: begin
                        res_rst_q   <= 1'b0;
                        mm_rst_q    <= 1'b0;
                        addr_q      <= '0;
                        hist_addr_q <= '0;
                        init_cnt_q  <= '0;
                        run_cnt_q   <= '0;
                        issue_q     <= 1'b1;
                        if (init_cfg_q == '0) begin
                            run_issue_q <= 1'b1;
                            state_q     <= S_RUN;
                        end else begin
                            state_q     <= S_INIT;
                        end
                    end
                    S_INIT: begin
                        addr_q <= addr_q + 1'b1;
                        if (init_cnt_q == init_cfg_q - 1'b1) begin
                            run_issue_q <= 1'b1;
                            state_q     <= S_RUN;
                        end else begin
                            init_cnt_q  <= init_cnt_q + 1'b1;
                        end
                    end
                    S_RUN: begin
                        addr_q <= addr_q + 1'b1;
                        if (run_cnt_q == total_q - 1'b1) begin
                            issue_q     <= 1'b0;
                            run_issue_q <= 1'b0;
                            drain_cnt_q <= '0;
                            state_q     <= S_DRAIN;
                        end else begin
                            run_cnt_q   <= run_cnt_q + 1'b1;
                        end
                    end
                    // The last history write leaves the pipe after exactly WEN_DEPTH drain cycles.
                    S_DRAIN: begin
                        if (drain_cnt_q == DRAIN_W'(WEN_DEPTH - 1)) begin
                            if (skip_mm_q) begin
                                done_q     <= 1'b1;
                                state_q    <= S_DONE;
                            end else begin
                                mm_start_q <= 1'b1;
                                state_q    <= S_MM_START;
                            end
                        end else begin
                            drain_cnt_q <= drain_cnt_q + 1'b1;
                        end
                    end
                    S_MM_START: begin
                        mm_start_q <= 1'b0;
                        mm_first_q <= 1'b1;
                        state_q    <= S_MM_WAIT;
                    end
                    // The multiplier raises busy a cycle after start, so the first sample is skipped.
                    S_MM_WAIT: begin
                        if (mm_first_q) begin
                            mm_first_q <= 1'b0;
                        end else if (!mm_busy) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    S_ABORT: begin
                        res_rst_q <= 1'b0;
                        mm_rst_q  <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign phase         = state_to_phase(state_q);
    assign input_addr    = addr_q;
    assign reservoir_en  = res_en_w;
    assign reservoir_rst = res_rst_q;
    assign history_wen   = hist_wen_w;
    assign history_addr  = hist_addr_q;
    assign mm_start      = mm_start_q;
    assign mm_rst        = mm_rst_q;
    assign mm_x_rows     = samples_q;
    assign mm_x_cols     = steps_q;
    assign mm_y_cols     = outputs_q;

endmodule
